// File: rtl/key_evt_pkg.sv
// Shared constants and record helpers for the key event arbiter.
package key_evt_pkg;

    localparam logic EVT_CLICK  = 1'b0;
    localparam logic EVT_LPRESS = 1'b1;

    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned KEY_W_MAX  = 3;

    // Widest event record; narrower builds pack {key, type} into evt_w(NKEY) bits.
    typedef struct packed {
        logic [KEY_W_MAX-1:0] key;
        logic                 typ;
    } key_evt_t;

    function automatic int unsigned key_w(input int unsigned nkey);
        return (nkey > 1) ? $clog2(nkey) : 1;
    endfunction

    function automatic int unsigned evt_w(input int unsigned nkey);
        return key_w(nkey) + 1;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO with registered occupancy; head read straight from storage.
module key_evt_fifo #(
    parameter int unsigned W     = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_din,
    output logic [W-1:0]             o_dout_c,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full_c,
    output logic                     o_empty_c
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = (r_level == LVL_W'(DEPTH));
    assign o_empty_c = (r_level == '0);
    assign w_push    = i_push & ~o_full_c;
    assign w_pop     = i_pop & ~o_empty_c;
    assign o_dout_c  = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/key_evt_arbiter.sv
// Pending flags, round-robin grant into the event FIFO, and overflow tracking.
// Optional drop counter enabled by defining KEY_EVT_DROP_CNT_EN.
module key_evt_arbiter
    import key_evt_pkg::*;
#(
    parameter int unsigned NKEY  = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NKEY-1:0]           click,
    input  logic [NKEY-1:0]           lpress,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [key_w(NKEY)-1:0]    evt_key,
    output logic                      evt_type,
    output logic [$clog2(DEPTH):0]    evt_level,
    output logic                      ovf,
    input  logic                      ovf_clr
`ifdef KEY_EVT_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]     drop_cnt
`endif
);

    localparam int unsigned KEY_W = key_w(NKEY);
    localparam int unsigned EVT_W = evt_w(NKEY);
    localparam int unsigned NREQ  = 2 * NKEY;
    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [NREQ-1:0]  r_pend;
    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_ovf;

    logic [NREQ-1:0]  w_pulse;
    logic [NREQ-1:0]  w_gnt;
    logic [NREQ-1:0]  w_drop;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [EVT_W-1:0] w_push_evt;
    logic [EVT_W-1:0] w_head;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned k);
        return PTR_W'((32'(p) + k) % NREQ);
    endfunction

    // Interleave keys into the request vector: bit 2k click, bit 2k+1 long press.
    always_comb begin
        w_pulse = '0;
        for (int k = 0; k < NKEY; k++) begin
            w_pulse[2*k]   = click[k];
            w_pulse[2*k+1] = lpress[k];
        end
    end

    // A full FIFO at the start of the cycle blocks the grant even if it pops.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
        if (!w_full) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!w_gnt_vld && r_pend[ptr_add(r_rr_ptr, i)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = ptr_add(r_rr_ptr, i);
                end
            end
        end
        if (w_gnt_vld) w_gnt[w_gnt_idx] = 1'b1;
    end

    assign w_drop     = w_pulse & r_pend & ~w_gnt;
    assign w_push_evt = {KEY_W'(w_gnt_idx >> 1), (w_gnt_idx[0] ? EVT_LPRESS : EVT_CLICK)};
    assign w_pop      = evt_valid & evt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend   <= '0;
            r_rr_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_gnt) | w_pulse;
            if (w_gnt_vld) r_rr_ptr <= ptr_add(w_gnt_idx, 1);
            if (|w_drop)      r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    key_evt_fifo #(
        .W     (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_gnt_vld),
        .i_pop     (w_pop),
        .i_din     (w_push_evt),
        .o_dout_c  (w_head),
        .o_level   (evt_level),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    assign evt_valid = ~w_empty;
    assign evt_key   = evt_valid ? w_head[EVT_W-1:1] : '0;
    assign evt_type  = evt_valid ? w_head[0] : 1'b0;
    assign ovf       = r_ovf;

`ifdef KEY_EVT_DROP_CNT_EN
    localparam int unsigned NDROP_W = $clog2(NREQ + 1);
    localparam int unsigned SUM_W   = DROP_CNT_W + 1;

    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [NDROP_W-1:0]    w_ndrop;
    logic [SUM_W-1:0]      w_cnt_sum;

    // A clear in the same cycle as drops restarts the count from this cycle's drops.
    always_comb begin
        w_ndrop = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_ndrop = w_ndrop + NDROP_W'(w_drop[k]);
        end
        w_cnt_sum = ovf_clr ? SUM_W'(w_ndrop) : ({1'b0, r_drop_cnt} + SUM_W'(w_ndrop));
    end

    always_ff @(posedge clk) begin
        if (rst) r_drop_cnt <= '0;
        else     r_drop_cnt <= w_cnt_sum[DROP_CNT_W] ? '1 : w_cnt_sum[DROP_CNT_W-1:0];
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
